watch_button_ctrl: RTL and testbench
====================================

WATCH_BUTTON_CTRL -- requirements
Module: watch_button_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a button level change (must be >= 1).
REQ-002 SHALL have parameter REPEAT_DELAY, default 8: hold cycles from the first upTime pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_RATE, default 4: cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports btn_mode, btn_set, btn_next, btn_up, btn_reset, btn_start, btn_stop, each input, 1 bit: raw asynchronous active-high pushbuttons.
REQ-007 SHALL have port mode, output, 3 bits: display mode, 0=WATCH, 1=STOPWATCH, 2=ALARM, 3=DAY.
REQ-008 SHALL have port setValue, output, 1 bit: set-mode level.
REQ-009 SHALL have ports nextd, upTime, resetTime, start_resume, stop, each output, 1 bit: one-cycle command pulses.

Function
REQ-010 SHALL pass each raw button through a 2-flop synchronizer.
REQ-011 SHALL debounce per button: the counter increments each cycle the synchronized level differs from the debounced level, and clears when they match; the debounced level flips when the count reaches DEBOUNCE_CYCLES, and the counter then clears.
REQ-012 SHALL create a press event on the 0->1 transition of a debounced level; releases create no event.
REQ-013 SHALL register every output; stable input to pulse latency is exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the raw input high.
REQ-014 SHALL advance mode on a btn_mode press, 0->1->2->3->0 (values 4-7 are never produced), and only while setValue=0.
REQ-015 SHALL toggle setValue on a btn_set press when mode is 0, 2 or 3; a btn_set press in mode 1 is ignored.
REQ-016 SHALL give btn_set priority when btn_set and btn_mode press events fall in the same cycle; that mode press is discarded.
REQ-017 SHALL pulse nextd for one cycle on a btn_next press only while setValue=1.
REQ-018 SHALL pulse upTime for one cycle on a btn_up press only while setValue=1.
REQ-019 SHALL auto-repeat upTime while btn_up stays debounced-high: one pulse at REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_RATE cycles.
REQ-020 SHALL stop auto-repeat and clear the repeat counter immediately on debounced release or when setValue falls.
REQ-021 SHALL pulse resetTime for one cycle on a btn_reset press in any mode or set state.
REQ-022 SHALL pulse start_resume or stop for one cycle on a btn_start or btn_stop press, only while setValue=0, in any mode.
REQ-023 SHALL process independent button presses in the same cycle in parallel (e.g. start_resume and stop both pulse).
REQ-024 SHALL never hold any pulse output high for two consecutive cycles, except upTime when REPEAT_RATE=1.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, clear mode to 0, setValue, all pulse outputs, synchronizers, debounced levels and all counters to 0.
REQ-026 SHALL register a press for a button held through reset deassertion after the normal REQ-013 latency.
REQ-027 SHALL let reset asserted mid-debounce or mid-repeat abort the operation with no pulse emitted.

Verification
REQ-028 SHALL cover: btn_start high at edge 0, held, setValue=0 -> start_resume=1 for exactly one cycle after edge 7, then 0.
REQ-029 SHALL cover: btn_mode bouncing 1,0,1,0, then stable 1 -> a single mode increment, 4+3 edges after the last rising bounce.
REQ-030 SHALL cover: four clean btn_mode presses from reset -> mode 1, 2, 3, 0.
REQ-031 SHALL cover: mode=0, press btn_set, then hold btn_up for 30 cycles -> setValue=1; upTime pulses at P, P+8, P+12, P+16, P+20, P+24, P+28 with none after release; btn_mode presses are ignored.
REQ-032 SHALL cover: mode=1, press btn_set -> setValue stays 0; btn_set and btn_mode pressed in the same cycle from mode 0 -> setValue=1, mode stays 0.
REQ-033 SHALL cover: reset asserted during an upTime hold in set mode -> all outputs 0 the next cycle, mode=0, and a new press is needed after the held-button re-debounce.

Source files
------------

// File: rtl/watch_button_ctrl.sv
// Pushbutton front end for a digital watch: synchronizes and debounces seven raw
// buttons, then turns press events into mode/set state and one-cycle command pulses.
module watch_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  output logic [2:0] mode,
  output logic       setValue,
  output logic       nextd,
  output logic       upTime,
  output logic       resetTime,
  output logic       start_resume,
  output logic       stop
);

  localparam int NB      = 7;
  localparam int B_MODE  = 0;
  localparam int B_SET   = 1;
  localparam int B_NEXT  = 2;
  localparam int B_UP    = 3;
  localparam int B_RESET = 4;
  localparam int B_START = 5;
  localparam int B_STOP  = 6;

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LIMIT = DCW'(DEBOUNCE_CYCLES);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RCW-1:0] DELAY_LOAD = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RATE_LOAD  = RCW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    MODE_WATCH     = 3'd0,
    MODE_STOPWATCH = 3'd1,
    MODE_ALARM     = 3'd2,
    MODE_DAY       = 3'd3
  } mode_t;

  mode_t           mode_q;
  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync1;
  logic [NB-1:0]   sync2;
  logic [NB-1:0]   deb;
  logic [NB-1:0]   deb_prev;
  logic [NB-1:0]   press;
  logic [DCW-1:0]  db_cnt [NB];
  logic            rpt_active;
  logic [RCW-1:0]  rpt_cnt;
  logic            rpt_fire;

  assign raw   = {btn_stop, btn_start, btn_reset, btn_up, btn_next, btn_set, btn_mode};
  assign press = deb & ~deb_prev;
  assign mode  = mode_q;

  // Repeat pulses only while the repeat is armed and the hold is still valid.
  assign rpt_fire = rpt_active && (rpt_cnt == '0) && deb[B_UP] && setValue;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LIMIT) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_WATCH;
      setValue     <= 1'b0;
      nextd        <= 1'b0;
      upTime       <= 1'b0;
      resetTime    <= 1'b0;
      start_resume <= 1'b0;
      stop         <= 1'b0;
      rpt_active   <= 1'b0;
      rpt_cnt      <= '0;
    end else begin
      nextd        <= press[B_NEXT] & setValue;
      upTime       <= (press[B_UP] & setValue) | rpt_fire;
      resetTime    <= press[B_RESET];
      start_resume <= press[B_START] & ~setValue;
      stop         <= press[B_STOP] & ~setValue;

      // A set press swallows any mode press landing in the same cycle.
      if (press[B_SET]) begin
        if (mode_q != MODE_STOPWATCH) setValue <= ~setValue;
      end else if (press[B_MODE] && !setValue) begin
        mode_q <= (mode_q == MODE_DAY) ? MODE_WATCH : mode_t'(mode_q + 3'd1);
      end

      if (!deb[B_UP] || !setValue) begin
        rpt_active <= 1'b0;
        rpt_cnt    <= '0;
      end else if (press[B_UP]) begin
        rpt_active <= 1'b1;
        rpt_cnt    <= DELAY_LOAD;
      end else if (rpt_active) begin
        rpt_cnt <= (rpt_cnt == '0) ? RATE_LOAD : rpt_cnt - RCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_watch_button_ctrl.sv
// Scoreboard bench for watch_button_ctrl: stimulus pushes expected output events,
// an independent monitor pops and compares them whenever the DUT shows activity.
module tb_watch_button_ctrl;

  localparam logic [6:0] M_MODE  = 7'b0000001;
  localparam logic [6:0] M_SET   = 7'b0000010;
  localparam logic [6:0] M_NEXT  = 7'b0000100;
  localparam logic [6:0] M_UP    = 7'b0001000;
  localparam logic [6:0] M_RESET = 7'b0010000;
  localparam logic [6:0] M_START = 7'b0100000;
  localparam logic [6:0] M_STOP  = 7'b1000000;

  localparam logic [4:0] P_NONE  = 5'b00000;
  localparam logic [4:0] P_NEXT  = 5'b10000;
  localparam logic [4:0] P_UP    = 5'b01000;
  localparam logic [4:0] P_RST   = 5'b00100;
  localparam logic [4:0] P_START = 5'b00010;
  localparam logic [4:0] P_STOP  = 5'b00001;

  localparam int LAT = 7;

  typedef struct {
    int         cyc;
    logic [4:0] pulses;
    logic [2:0] mode;
    logic       set;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] btns;
  logic [2:0] mode;
  logic       setValue, nextd, upTime, resetTime, start_resume, stop;

  exp_t       sbq[$];
  exp_t       e_mon;
  exp_t       e_end;
  int         edge_n = 0;
  int         total = 0;
  int         bad = 0;
  int         t0, t1;
  logic [4:0] obs;
  logic [2:0] last_mode = 3'd0;
  logic       last_set = 1'b0;

  watch_button_ctrl dut (
    .clk(clk), .reset(reset),
    .btn_mode(btns[0]), .btn_set(btns[1]), .btn_next(btns[2]), .btn_up(btns[3]),
    .btn_reset(btns[4]), .btn_start(btns[5]), .btn_stop(btns[6]),
    .mode(mode), .setValue(setValue), .nextd(nextd), .upTime(upTime),
    .resetTime(resetTime), .start_resume(start_resume), .stop(stop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Any pulse, or any change of mode/setValue, must match the head of the queue.
  always @(negedge clk) begin
    obs = {nextd, upTime, resetTime, start_resume, stop};
    if (!reset && (obs != 5'b0 || mode != last_mode || setValue != last_set)) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_event edge=%0d got pulses=%b mode=%0d set=%0b, queue empty",
                 edge_n, obs, mode, setValue);
      end else begin
        e_mon = sbq.pop_front();
        if (e_mon.cyc != edge_n || e_mon.pulses != obs || e_mon.mode != mode || e_mon.set != setValue) begin
          bad++;
          $display("[TB] FAIL event got edge=%0d pulses=%b mode=%0d set=%0b, want edge=%0d pulses=%b mode=%0d set=%0b",
                   edge_n, obs, mode, setValue, e_mon.cyc, e_mon.pulses, e_mon.mode, e_mon.set);
        end
      end
    end
    last_mode = mode;
    last_set  = setValue;
  end

  task automatic pushExpect(input int cyc, input logic [4:0] p, input logic [2:0] m, input logic s);
    exp_t e;
    e.cyc = cyc; e.pulses = p; e.mode = m; e.set = s;
    sbq.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  // Clean press: hold 10 cycles, release, let the release debounce out.
  task automatic applyStimulus(input logic [6:0] mask, input bit expect_evt,
                               input logic [4:0] p, input logic [2:0] m, input logic s);
    int ts;
    btns = btns | mask;
    ts = edge_n + 1;
    if (expect_evt) pushExpect(ts + LAT, p, m, s);
    waitCycles(10);
    btns = btns & ~mask;
    waitCycles(12);
  endtask

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog edge=%0d limit reached", edge_n);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset = 1'b1;
    btns  = '0;
    waitCycles(3);
    checkOutput("reset_mode", int'(mode), 0);
    checkOutput("reset_set", int'(setValue), 0);
    checkOutput("reset_pulses", int'({nextd, upTime, resetTime, start_resume, stop}), 0);
    reset = 1'b0;
    waitCycles(3);

    applyStimulus(M_START, 1, P_START, 3'd0, 1'b0);
    applyStimulus(M_START | M_STOP, 1, P_START | P_STOP, 3'd0, 1'b0);
    applyStimulus(M_RESET, 1, P_RST, 3'd0, 1'b0);
    applyStimulus(M_NEXT | M_UP, 0, P_NONE, 3'd0, 1'b0);

    // Bouncy mode press: only the final stable level counts.
    for (int i = 0; i < 4; i++) begin
      btns[0] = (i % 2 == 0);
      waitCycles(1);
    end
    applyStimulus(M_MODE, 1, P_NONE, 3'd1, 1'b0);
    for (int k = 2; k <= 4; k++) applyStimulus(M_MODE, 1, P_NONE, 3'(k % 4), 1'b0);

    applyStimulus(M_SET | M_MODE, 1, P_NONE, 3'd0, 1'b1);
    applyStimulus(M_MODE, 0, P_NONE, 3'd0, 1'b1);
    applyStimulus(M_NEXT, 1, P_NEXT, 3'd0, 1'b1);
    applyStimulus(M_START, 0, P_NONE, 3'd0, 1'b1);
    applyStimulus(M_RESET, 1, P_RST, 3'd0, 1'b1);

    // Held up button in set mode: initial pulse then auto-repeat.
    btns = btns | M_UP;
    t0 = edge_n + 1;
    pushExpect(t0 + LAT, P_UP, 3'd0, 1'b1);
    for (int k = 8; k <= 28; k += 4) pushExpect(t0 + LAT + k, P_UP, 3'd0, 1'b1);
    waitCycles(30);
    btns = btns & ~M_UP;
    waitCycles(15);

    applyStimulus(M_SET, 1, P_NONE, 3'd0, 1'b0);
    applyStimulus(M_MODE, 1, P_NONE, 3'd1, 1'b0);
    applyStimulus(M_SET, 0, P_NONE, 3'd1, 1'b0);
    applyStimulus(M_MODE, 1, P_NONE, 3'd2, 1'b0);
    applyStimulus(M_SET, 1, P_NONE, 3'd2, 1'b1);

    // Reset in the middle of an up-repeat; start stays held across reset.
    btns = btns | M_UP | M_START;
    t0 = edge_n + 1;
    pushExpect(t0 + LAT, P_UP, 3'd2, 1'b1);
    waitCycles(12);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("rst_mid_mode", int'(mode), 0);
    checkOutput("rst_mid_set", int'(setValue), 0);
    checkOutput("rst_mid_pulses", int'({nextd, upTime, resetTime, start_resume, stop}), 0);
    waitCycles(1);
    reset = 1'b0;
    t1 = edge_n + 1;
    pushExpect(t1 + LAT, P_START, 3'd0, 1'b0);
    waitCycles(12);
    btns = '0;
    waitCycles(12);

    while (sbq.size() > 0) begin
      e_end = sbq.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL missing_event got=none want edge=%0d pulses=%b mode=%0d set=%0b",
               e_end.cyc, e_end.pulses, e_end.mode, e_end.set);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
